// File: rtl/myadder1_example_pkg.sv
// ============================================================================
//  Module   : myadder1_example_pkg
//  Brief    : Shared types, default geometry and helpers for the stream generator
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package myadder1_example_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int LP_BYTES     = 512 / 8;
  localparam int LP_NUM_LANES = 512 / 32;

  // One extra bit over the byte-length field keeps the ceiling division from overflowing.
  function automatic int beat_cnt_width(input int len_width, input int bytes);
    return len_width + 1 - $clog2(bytes);
  endfunction

endpackage : myadder1_example_pkg

`default_nettype wire

// File: rtl/myadder1_example_stream_gen_pattern.sv
// ============================================================================
//  Module   : myadder1_example_stream_gen_pattern
//  Brief    : Combinational lane pattern, lane i = base + beat*LANES + i (mod 2^W)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module myadder1_example_stream_gen_pattern
  import myadder1_example_pkg::*;
#(
  parameter int C_AXIS_TDATA_WIDTH = 512,
  parameter int C_ADDER_BIT_WIDTH  = 32,
  parameter int C_BEAT_WIDTH       = 27
) (
  input  logic [C_ADDER_BIT_WIDTH-1:0]  base_i,
  input  logic [C_BEAT_WIDTH-1:0]       beat_i,
  output logic [C_AXIS_TDATA_WIDTH-1:0] data_o
);

  localparam int LANES = C_AXIS_TDATA_WIDTH / C_ADDER_BIT_WIDTH;

  logic [C_ADDER_BIT_WIDTH-1:0] w_beat_base;

  // Truncating the beat index is harmless: only the result modulo 2^W matters.
  assign w_beat_base = base_i
                     + C_ADDER_BIT_WIDTH'(beat_i) * C_ADDER_BIT_WIDTH'(LANES);

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign data_o[gi*C_ADDER_BIT_WIDTH +: C_ADDER_BIT_WIDTH] =
      w_beat_base + C_ADDER_BIT_WIDTH'(gi);
  end

endmodule : myadder1_example_stream_gen_pattern

`default_nettype wire

// File: rtl/myadder1_example_stream_gen.sv
// ============================================================================
//  Module   : myadder1_example_stream_gen
//  Brief    : AXI4-Stream packet generator with per-lane counting pattern.
//             Define MYADDER1_STREAM_GEN_THROTTLE_EN to insert a one-cycle
//             tvalid gap after every non-final beat.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module myadder1_example_stream_gen
  import myadder1_example_pkg::*;
#(
  parameter int C_AXIS_TDATA_WIDTH = 512,
  parameter int C_ADDER_BIT_WIDTH  = 32,
  parameter int C_LEN_WIDTH        = 32
) (
  input  logic                            m_axis_aclk,
  input  logic                            m_axis_aresetn,
  input  logic                            ctrl_start,
  input  logic [C_LEN_WIDTH-1:0]          ctrl_length,
  input  logic [C_ADDER_BIT_WIDTH-1:0]    ctrl_seed,
  output logic                            ctrl_busy,
  output logic                            ctrl_done,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic [C_AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                            m_axis_tlast
);

  localparam int BYTES = C_AXIS_TDATA_WIDTH / 8;
  localparam int BSH   = $clog2(BYTES);
  localparam int CNT_W = beat_cnt_width(C_LEN_WIDTH, BYTES);

  state_e                         state_q, state_d;
  logic [CNT_W-1:0]               beat_q, beat_d;
  logic [CNT_W-1:0]               nbeats_q, nbeats_d;
  logic [BSH-1:0]                 rem_q, rem_d;
  logic [C_ADDER_BIT_WIDTH-1:0]   seed_q, seed_d;
  logic                           tvalid_q, tvalid_d;
  logic [C_AXIS_TDATA_WIDTH-1:0]  tdata_q, tdata_d;
  logic [BYTES-1:0]               tkeep_q, tkeep_d;
  logic                           tlast_q, tlast_d;
  logic                           busy_q, busy_d;
  logic                           done_q, done_d;
`ifdef MYADDER1_STREAM_GEN_THROTTLE_EN
  logic                           gap_q, gap_d;
`endif

  logic [C_LEN_WIDTH:0]           w_len_ext;
  logic [CNT_W-1:0]               w_start_nbeats;
  logic [BSH-1:0]                 w_start_rem;
  logic [CNT_W-1:0]               w_beat_next;
  logic                           w_next_last;
  logic                           w_hs;
  logic [C_ADDER_BIT_WIDTH-1:0]   w_pat_base;
  logic [CNT_W-1:0]               w_pat_beat;
  logic [C_AXIS_TDATA_WIDTH-1:0]  w_pat_data;

  function automatic logic [BYTES-1:0] f_keep(input logic [BSH-1:0] rem);
    logic [BYTES-1:0] ones;
    ones = '1;
    if (rem == '0) return ones;
    return ~(ones << rem);
  endfunction

  assign w_len_ext      = {1'b0, ctrl_length} + (C_LEN_WIDTH+1)'(BYTES - 1);
  assign w_start_nbeats = CNT_W'(w_len_ext >> BSH);
  assign w_start_rem    = ctrl_length[BSH-1:0];
  assign w_beat_next    = beat_q + CNT_W'(1);
  assign w_next_last    = (w_beat_next == nbeats_q - CNT_W'(1));
  assign w_hs           = tvalid_q & m_axis_tready;

  // The pattern unit always computes the beat that will be loaded next.
  assign w_pat_base = (state_q == IDLE) ? ctrl_seed : seed_q;
  assign w_pat_beat = (state_q == IDLE) ? '0 : w_beat_next;

  myadder1_example_stream_gen_pattern #(
    .C_AXIS_TDATA_WIDTH (C_AXIS_TDATA_WIDTH),
    .C_ADDER_BIT_WIDTH  (C_ADDER_BIT_WIDTH),
    .C_BEAT_WIDTH       (CNT_W)
  ) u_pattern (
    .base_i (w_pat_base),
    .beat_i (w_pat_beat),
    .data_o (w_pat_data)
  );

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    nbeats_d = nbeats_q;
    rem_d    = rem_q;
    seed_d   = seed_q;
    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;
    tkeep_d  = tkeep_q;
    tlast_d  = tlast_q;
`ifdef MYADDER1_STREAM_GEN_THROTTLE_EN
    gap_d    = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (ctrl_start) begin
          seed_d   = ctrl_seed;
          nbeats_d = w_start_nbeats;
          rem_d    = w_start_rem;
          beat_d   = '0;
          if (w_start_nbeats == '0) begin
            state_d = DONE;
          end else begin
            state_d  = RUN;
            tvalid_d = 1'b1;
            tdata_d  = w_pat_data;
            tlast_d  = (w_start_nbeats == CNT_W'(1));
            tkeep_d  = (w_start_nbeats == CNT_W'(1)) ? f_keep(w_start_rem) : '1;
          end
        end
      end
      RUN: begin
`ifdef MYADDER1_STREAM_GEN_THROTTLE_EN
        if (gap_q) tvalid_d = 1'b1;
`endif
        if (w_hs) begin
          if (tlast_q) begin
            state_d  = DONE;
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
          end else begin
            beat_d  = w_beat_next;
            tdata_d = w_pat_data;
            tlast_d = w_next_last;
            tkeep_d = w_next_last ? f_keep(rem_q) : '1;
`ifdef MYADDER1_STREAM_GEN_THROTTLE_EN
            tvalid_d = 1'b0;
            gap_d    = 1'b1;
`endif
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
    if (!m_axis_aresetn) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      nbeats_q <= '0;
      rem_q    <= '0;
      seed_q   <= '0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tkeep_q  <= '0;
      tlast_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef MYADDER1_STREAM_GEN_THROTTLE_EN
      gap_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      nbeats_q <= nbeats_d;
      rem_q    <= rem_d;
      seed_q   <= seed_d;
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
      tkeep_q  <= tkeep_d;
      tlast_q  <= tlast_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef MYADDER1_STREAM_GEN_THROTTLE_EN
      gap_q    <= gap_d;
`endif
    end
  end

  assign ctrl_busy     = busy_q;
  assign ctrl_done     = done_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tkeep  = tkeep_q;
  assign m_axis_tlast  = tlast_q;

endmodule : myadder1_example_stream_gen

`default_nettype wire

// File: tb/tb_myadder1_example_stream_gen.sv
// ============================================================================
//  Module   : tb_myadder1_example_stream_gen
//  Brief    : Self-checking bench for the stream generator (512b data, 32b lanes)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_myadder1_example_stream_gen;

  logic         clk;
  logic         rst_n;
  logic         ctrl_start;
  logic [31:0]  ctrl_length;
  logic [31:0]  ctrl_seed;
  logic         ctrl_busy;
  logic         ctrl_done;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic [511:0] m_axis_tdata;
  logic [63:0]  m_axis_tkeep;
  logic         m_axis_tlast;

  int errors = 0;
  int checks = 0;

`ifdef MYADDER1_STREAM_GEN_THROTTLE_EN
  localparam bit THR = 1'b1;
`else
  localparam bit THR = 1'b0;
`endif

  myadder1_example_stream_gen #(
    .C_AXIS_TDATA_WIDTH (512),
    .C_ADDER_BIT_WIDTH  (32),
    .C_LEN_WIDTH        (32)
  ) dut (
    .m_axis_aclk    (clk),
    .m_axis_aresetn (rst_n),
    .ctrl_start     (ctrl_start),
    .ctrl_length    (ctrl_length),
    .ctrl_seed      (ctrl_seed),
    .ctrl_busy      (ctrl_busy),
    .ctrl_done      (ctrl_done),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tkeep   (m_axis_tkeep),
    .m_axis_tlast   (m_axis_tlast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: 16 lanes of seed + 16*b + i, wrapping at 32 bits.
  function automatic logic [511:0] exp_data(input logic [31:0] seed, input int b);
    logic [511:0] d;
    for (int i = 0; i < 16; i++) d[i*32 +: 32] = seed + 32'(b * 16 + i);
    return d;
  endfunction

  function automatic logic [63:0] exp_keep(input int b, input int n, input int r);
    if (b == n - 1 && r != 0) return (64'd1 << r) - 64'd1;
    return {64{1'b1}};
  endfunction

  // mode 0: tready always high, 1: random tready, 2: 5-cycle stall on beat 1 plus a stray start
  task automatic run_packet(input logic [31:0] seed, input int len, input int mode);
    int  n, r, got, last_hs, stall_left, bound;
    bit  gap, done_seen, exp_v, rdy;
    n = (len + 63) / 64;
    r = len % 64;
    got = 0; last_hs = 0; gap = 1'b0; done_seen = 1'b0;
    stall_left = (mode == 2) ? 5 : 0;
    bound = 6 * n + 20;
    @(posedge clk); #1;
    chk("idle_tvalid", m_axis_tvalid, 1'b0);
    chk("idle_busy", ctrl_busy, 1'b0);
    ctrl_seed = seed; ctrl_length = len; ctrl_start = 1'b1; m_axis_tready = 1'b1;
    @(posedge clk); #1;
    ctrl_start = 1'b0; ctrl_seed = $urandom; ctrl_length = $urandom;
    for (int cyc = 1; cyc <= bound && !done_seen; cyc++) begin
      if (cyc > 1) begin @(posedge clk); #1; end
      ctrl_start = 1'b0;
      if (got == n) begin
        chk("done", ctrl_done, 1'b1);
        chk("done_tvalid", m_axis_tvalid, 1'b0);
        chk("done_busy", ctrl_busy, 1'b0);
        chk("done_cycle", cyc, (n == 0) ? 1 : last_hs + 1);
        done_seen = 1'b1;
      end else begin
        exp_v = !gap;
        chk("tvalid", m_axis_tvalid, exp_v);
        chk("busy", ctrl_busy, 1'b1);
        chk("not_done", ctrl_done, 1'b0);
        if (exp_v) begin
          chk("tdata", m_axis_tdata, exp_data(seed, got));
          chk("tkeep", m_axis_tkeep, exp_keep(got, n, r));
          chk("tlast", m_axis_tlast, got == n - 1);
        end
        if (mode == 1) rdy = 1'($urandom % 2);
        else if (mode == 2 && got == 1 && stall_left > 0) begin
          rdy = 1'b0; stall_left--;
        end else rdy = 1'b1;
        if (mode == 2 && cyc == 2) begin
          ctrl_start = 1'b1; ctrl_length = 0; ctrl_seed = 32'hDEAD_BEEF;
        end
        m_axis_tready = rdy;
        gap = 1'b0;
        if (exp_v && rdy) begin
          got++;
          last_hs = cyc;
          if (THR && got < n) gap = 1'b1;
        end
      end
    end
    if (!done_seen) chk("timeout", 1'b0, 1'b1);
    ctrl_start = 1'b0;
    m_axis_tready = 1'b1;
  endtask

  initial begin
    int lens[4];
    logic [31:0] s;
    rst_n = 1'b0; ctrl_start = 1'b0; ctrl_length = '0; ctrl_seed = '0; m_axis_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", m_axis_tvalid, 1'b0);
    chk("rst_tlast", m_axis_tlast, 1'b0);
    chk("rst_tdata", m_axis_tdata, 512'd0);
    chk("rst_tkeep", m_axis_tkeep, 64'd0);
    chk("rst_busy", ctrl_busy, 1'b0);
    chk("rst_done", ctrl_done, 1'b0);
    rst_n = 1'b1;

    run_packet(32'h0, 128, 0);
    run_packet(32'h0, 100, 0);
    run_packet(32'h0, 0, 0);
    run_packet(32'hFFFF_FFF8, 64, 0);
    run_packet($urandom, 192, 2);

    // Asynchronous reset while beat 2 of a 3-beat packet is on the bus
    s = $urandom;
    @(posedge clk); #1;
    ctrl_seed = s; ctrl_length = 192; ctrl_start = 1'b1; m_axis_tready = 1'b1;
    @(posedge clk); #1;
    ctrl_start = 1'b0;
    while (!(m_axis_tvalid && m_axis_tdata[31:0] == s + 32'd32) && ctrl_busy) begin
      @(posedge clk); #1;
    end
    chk("pre_rst_beat2", m_axis_tdata[31:0], s + 32'd32);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_tvalid", m_axis_tvalid, 1'b0);
    chk("midrst_busy", ctrl_busy, 1'b0);
    chk("midrst_done", ctrl_done, 1'b0);
    chk("midrst_tlast", m_axis_tlast, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("postrst_tvalid", m_axis_tvalid, 1'b0);
    chk("postrst_done", ctrl_done, 1'b0);

    lens[0] = 1; lens[1] = 63; lens[2] = 64; lens[3] = 65;
    foreach (lens[k]) run_packet($urandom, lens[k], 0);
    for (int k = 0; k < 6; k++) run_packet($urandom, $urandom_range(1, 700), 1);
    run_packet(32'h0, 256, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_myadder1_example_stream_gen

`default_nettype wire
